multi_channel_frequency_divider: RTL
====================================

Name: multi_channel_frequency_divider

Overview:
- NCH independent, runtime-programmable clock dividers sharing one system clock; successor to the fixed 8-entry, select-driven single-output divider.
- Each channel has its own divisor, output mode (square / pulse), enable and period tick.
- Divisor changes are shadowed and take effect only at a period boundary, so outputs never glitch or emit a short period.
- Feeds channel/baud timing logic that needs several unrelated divided strobes.

Parameters:
- NCH, 4, number of divider channels (1..16)
- CNT_W, 32, counter and divisor width in bits
- CH_W, 2, width of channel index; must be >= clog2(NCH), minimum 1
- DEF_DIV, 8, divisor loaded into every channel at reset (must be >= 2)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset_n  input  1  synchronous reset, active-low
- en  input  NCH  per-channel run enable
- div_we  input  1  one-cycle write strobe for divisor/mode
- div_ch  input  CH_W  target channel of write
- div_val  input  CNT_W  new divisor N
- div_mode  input  1  0 = square wave, 1 = single-cycle pulse
- fout  output  NCH  divided outputs, registered
- tick  output  NCH  one-cycle strobe on final count of each period, registered
- pending  output  NCH  1 while a written divisor/mode awaits application

Behaviour:
- Reset (reset_n low at edge): cnt=0, active N=DEF_DIV, active mode=0, shadow cleared, fout=0, tick=0, pending=0. Reset dominates every other input, including div_we.
- Effective divisor: Neff = max(N, 2); div_val of 0 or 1 is stored as written but behaves as 2.
- Counter, per channel:
  - en=1: cnt increments; when cnt==Neff-1 it wraps to 0.
  - en=0: cnt forced to 0.
- Outputs, registered from the current cnt (1-cycle latency):
  - square mode: fout <= en && (cnt >= Neff>>1). Period is Neff cycles; high time is Neff - floor(Neff/2).
  - pulse mode: fout <= en && (cnt == Neff-1).
  - tick <= en && (cnt == Neff-1), in both modes.
- en falling: fout and tick are 0 from the next edge. en rising: cnt starts from 0, so the first period is a full period.
- Writes:
  - div_we=1 with div_ch < NCH loads that channel's shadow {div_val, div_mode} and sets pending.
  - div_ch >= NCH: write ignored, no state change.
  - A second write before application overwrites the shadow; the latest value wins.
- Application of a pending shadow into active N/mode, with pending cleared, happens on the first edge where either:
  - en=1 and cnt==Neff-1 (wrap edge; next period uses new value), or
  - en=0 (applied on that edge).
- Write and apply on the same edge: the apply uses the old shadow; the new shadow loads and pending stays 1.
- Channels are fully independent; writes to channel k never disturb cnt or fout of other channels.
- No combinational path from any input to any output.

Decomposition:
- Shared package: mode constants (MODE_SQUARE=0, MODE_PULSE=1), MIN_DIV=2, and a helper function for Neff.
- One natural sub-module, freq_div_channel: counter, shadow/active divisor, mode, output/tick registers. It is instantiated NCH times via generate, with a one-hot write decode in the top level.

Test Plan:
- Reset then en[0]=1 with DEF_DIV=8 -> fout[0] is 0 for 4 cycles then 1 for 4, repeating; tick[0] high once every 8 cycles, one cycle before fout falls.
- Write ch1 N=5 square, en[1]=1 -> fout[1] high 3 cycles, low 2, period 5; pending[1] clears at the first wrap.
- Mid-period (cnt=3 of N=8) write ch0 N=4 -> current period completes all 8 cycles, then period is 4; no short pulse; pending[0]=1 until the wrap edge.
- Write ch2 N=1 pulse mode, en[2]=1 -> fout[2] toggles 1,0,1,0 (Neff=2); write N=6 pulse -> single-cycle high every 6 cycles.
- Two writes to ch3 (N=10, then N=3) before wrap, plus a write with div_ch=NCH -> only N=3 applied; no channel affected by the out-of-range write.
- reset_n low mid-period while pending=1 -> next edge: all fout/tick/pending 0 and N=DEF_DIV; counting restarts cleanly after release.

Source files
------------

// File: rtl/multi_channel_frequency_divider_pkg.sv
// rtl/multi_channel_frequency_divider_pkg.sv - shared mode encoding and divisor helpers
package multi_channel_frequency_divider_pkg;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } div_mode_e;

    localparam int MIN_DIV = 2;

    // Divisors below MIN_DIV are kept as written but count as MIN_DIV.
    function automatic logic [63:0] eff_div(input logic [63:0] n);
        return (n < 64'(MIN_DIV)) ? 64'(MIN_DIV) : n;
    endfunction

endpackage

// File: rtl/multi_channel_frequency_divider_channel.sv
// rtl/multi_channel_frequency_divider_channel.sv - one divider channel with shadowed divisor
module multi_channel_frequency_divider_channel
    import multi_channel_frequency_divider_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int DEF_DIV = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_val,
    input  logic             wr_mode,
    output logic             fout,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_act;
    logic [CNT_W-1:0] n_sh;
    div_mode_e        mode_act;
    div_mode_e        mode_sh;

    logic [CNT_W-1:0] neff;
    logic [CNT_W-1:0] half;
    logic             at_end;
    logic             apply;

    always_comb begin
        neff   = CNT_W'(eff_div(64'(n_act)));
        half   = neff >> 1;
        at_end = (cnt == neff - CNT_W'(1));
        // Shadow moves to active only on a period boundary or while stopped.
        apply  = pending && (!en || at_end);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt      <= '0;
            n_act    <= CNT_W'(DEF_DIV);
            mode_act <= MODE_SQUARE;
            n_sh     <= '0;
            mode_sh  <= MODE_SQUARE;
            pending  <= 1'b0;
            fout     <= 1'b0;
            tick     <= 1'b0;
        end else begin
            if (!en || at_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (mode_act == MODE_PULSE) begin
                fout <= en && at_end;
            end else begin
                fout <= en && (cnt >= half);
            end
            tick <= en && at_end;

            if (apply) begin
                n_act    <= n_sh;
                mode_act <= mode_sh;
            end

            // A write on the apply edge lands in the shadow and keeps pending set.
            if (wr) begin
                n_sh    <= wr_val;
                mode_sh <= div_mode_e'(wr_mode);
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_channel_frequency_divider.sv
// rtl/multi_channel_frequency_divider.sv - NCH independent programmable clock dividers
module multi_channel_frequency_divider
    import multi_channel_frequency_divider_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int CNT_W   = 32,
    parameter int CH_W    = 2,
    parameter int DEF_DIV = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NCH-1:0]   en,
    input  logic             div_we,
    input  logic [CH_W-1:0]  div_ch,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_mode,
    output logic [NCH-1:0]   fout,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   pending
);

    logic [NCH-1:0] wr_sel;

    // Out-of-range channel indices match no entry, so such writes are dropped.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign wr_sel[i] = div_we && (div_ch == CH_W'(i));

        multi_channel_frequency_divider_channel #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (en[i]),
            .wr      (wr_sel[i]),
            .wr_val  (div_val),
            .wr_mode (div_mode),
            .fout    (fout[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end

endmodule
